// File: rtl/word_picker_pkg.sv
// Shared definitions for the word picker.
//   LETTER_W     bits per letter code (hex-digit style: A=6'h0A ... Z=6'h23)
//   L_A..L_Z     letter code constants
//   state_t      picker FSM states
//   WORD_ROM     eight 4-letter words, first letter in the low field
//   lfsr_taps()  XNOR feedback tap mask for LFSR widths 4..16
package word_picker_pkg;

   localparam int LETTER_W = 6;

   localparam logic [5:0] L_A = 6'h0A, L_B = 6'h0B, L_C = 6'h0C, L_D = 6'h0D,
                          L_E = 6'h0E, L_F = 6'h0F, L_G = 6'h10, L_H = 6'h11,
                          L_I = 6'h12, L_J = 6'h13, L_K = 6'h14, L_L = 6'h15,
                          L_M = 6'h16, L_N = 6'h17, L_O = 6'h18, L_P = 6'h19,
                          L_Q = 6'h1A, L_R = 6'h1B, L_S = 6'h1C, L_T = 6'h1D,
                          L_U = 6'h1E, L_V = 6'h1F, L_W = 6'h20, L_X = 6'h21,
                          L_Y = 6'h22, L_Z = 6'h23;

   typedef enum logic {
      IDLE = 1'b0,
      DRAW = 1'b1
   } state_t;

   // Concatenations are written last-letter-first so the first letter lands
   // in bits [5:0].
   localparam logic [4*LETTER_W-1:0] WORD_ROM [0:7] = '{
      {L_Y, L_A, L_T, L_S},   // STAY
      {L_N, L_R, L_A, L_D},   // DARN
      {L_E, L_F, L_I, L_L},   // LIFE
      {L_D, L_A, L_E, L_H},   // HEAD
      {L_P, L_M, L_U, L_J},   // JUMP
      {L_G, L_O, L_R, L_F},   // FROG
      {L_K, L_L, L_I, L_M},   // MILK
      {L_E, L_V, L_A, L_W}    // WAVE
   };

   // Maximal-length XNOR taps; tap position p maps to mask bit p-1. Every
   // entry has an even tap count, so all-ones is the lock-up state.
   function automatic logic [15:0] lfsr_taps(input int width);
      case (width)
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/word_picker_if.sv
// Controller-side bus of the word picker.
//   seed_load, seed   load a new LFSR seed (any state, single cycle)
//   pick              pick request
//   busy              draw in progress
//   word_valid        word_idx/letters hold a completed pick
//   word_idx, letters selected word index and its letter codes
// Handshake: pick is a request that is taken only on a clock edge where busy
// is low; while busy is high pick is ignored. word_valid is a level, not a
// pulse: it drops on the edge that takes a pick and rises on the edge that
// completes the draw, and word_idx/letters are stable whenever it is high.
interface word_picker_if #(
   parameter int LFSR_W   = 8,
   parameter int IDX_W    = 3,
   parameter int WORD_LEN = 4,
   parameter int LETTER_W = 6
);
   logic                         seed_load;
   logic [LFSR_W-1:0]            seed;
   logic                         pick;
   logic                         busy;
   logic                         word_valid;
   logic [IDX_W-1:0]             word_idx;
   logic [WORD_LEN*LETTER_W-1:0] letters;

   modport master (
      output seed_load, seed, pick,
      input  busy, word_valid, word_idx, letters
   );

   modport slave (
      input  seed_load, seed, pick,
      output busy, word_valid, word_idx, letters
   );
endinterface

// File: rtl/word_picker_rom.sv
// Combinational word table lookup.
//   idx      word index
//   letters  letter codes of that word; first letter in [LETTER_W-1:0]
// Indices at or above NUM_WORDS (or beyond the 8-word table) return all zeros,
// as do letter positions beyond the 4 stored letters.
module word_picker_rom #(
   parameter int NUM_WORDS = 8,
   parameter int WORD_LEN  = 4,
   parameter int LETTER_W  = word_picker_pkg::LETTER_W,
   parameter int IDX_W     = 3
) (
   input  logic [IDX_W-1:0]             idx,
   output logic [WORD_LEN*LETTER_W-1:0] letters
);
   import word_picker_pkg::*;

   localparam int PKG_W  = word_picker_pkg::LETTER_W;
   localparam int N_WORD = (NUM_WORDS < 8) ? NUM_WORDS : 8;
   localparam int N_LET  = (WORD_LEN < 4) ? WORD_LEN : 4;

   always_comb begin
      letters = '0;
      for (int w = 0; w < N_WORD; w++) begin
         if (int'(idx) == w) begin
            for (int i = 0; i < N_LET; i++) begin
               letters[i*LETTER_W +: LETTER_W] = LETTER_W'(WORD_ROM[w][i*PKG_W +: PKG_W]);
            end
         end
      end
   end

endmodule

// File: rtl/word_picker.sv
// Random word selector: free-running XNOR LFSR plus a multi-cycle draw FSM.
//   clk, rst   clock; asynchronous active-high reset
//   bus        word_picker_if slave (seed_load/seed/pick in; busy/word_valid/
//              word_idx/letters out)
//   dbg_state  current FSM state
//   dbg_lfsr   current LFSR contents
// A draw takes the low IDX_W LFSR bits each cycle and accepts the first index
// that is in range and (with NO_REPEAT) differs from the previous pick. After
// MAX_TRIES rejected draws it falls back to the index after the previous one.
module word_picker #(
   parameter int LFSR_W    = 8,
   parameter int NUM_WORDS = 8,
   parameter int WORD_LEN  = 4,
   parameter int LETTER_W  = word_picker_pkg::LETTER_W,
   parameter int NO_REPEAT = 1,
   parameter int MAX_TRIES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   word_picker_if.slave            bus,
   output word_picker_pkg::state_t dbg_state,
   output logic [LFSR_W-1:0]       dbg_lfsr
);
   import word_picker_pkg::*;

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W:0]    NW       = (IDX_W+1)'(NUM_WORDS);
   localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);

   state_t                       state_q, state_d;
   logic [LFSR_W-1:0]            lfsr;
   logic                         fb;
   logic [TRY_W-1:0]             try_cnt;
   logic                         have_last;
   logic                         word_valid_q;
   logic [IDX_W-1:0]             word_idx_q;
   logic [WORD_LEN*LETTER_W-1:0] letters_q;
   logic [WORD_LEN*LETTER_W-1:0] rom_letters;
   logic [IDX_W-1:0]             cand, pick_idx;
   logic                         cand_ok, start, accept;

   // ---------------- LFSR ----------------
   assign fb = ~^(lfsr & TAPS);

   // A seed load replaces the shift for that cycle; an all-ones seed would
   // lock the XNOR LFSR, so it is mapped to all-zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                lfsr <= '0;
      else if (bus.seed_load) lfsr <= (&bus.seed) ? '0 : bus.seed;
      else                    lfsr <= {lfsr[LFSR_W-2:0], fb};
   end

   // ---------------- draw FSM ----------------
   assign cand    = lfsr[IDX_W-1:0];
   assign cand_ok = ({1'b0, cand} < NW) &&
                    !((NO_REPEAT != 0) && have_last && (cand == word_idx_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      accept   = 1'b0;
      pick_idx = cand;
      case (state_q)
         IDLE: begin
            if (bus.pick) begin
               state_d = DRAW;
               start   = 1'b1;
            end
         end
         DRAW: begin
            if (cand_ok) begin
               accept  = 1'b1;
               state_d = IDLE;
            end else if (try_cnt == TRY_LAST) begin
               // Out of tries: step to the word after the previous one, which
               // can never repeat it because NUM_WORDS >= 2.
               accept  = 1'b1;
               state_d = IDLE;
               if (!have_last || word_idx_q == LAST_IDX) pick_idx = '0;
               else                                      pick_idx = word_idx_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   word_picker_rom #(
      .NUM_WORDS (NUM_WORDS),
      .WORD_LEN  (WORD_LEN),
      .LETTER_W  (LETTER_W),
      .IDX_W     (IDX_W)
   ) u_rom (
      .idx     (pick_idx),
      .letters (rom_letters)
   );

   // ---------------- output registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_valid_q <= 1'b0;
         word_idx_q   <= '0;
         letters_q    <= '0;
         have_last    <= 1'b0;
         try_cnt      <= '0;
      end else if (start) begin
         word_valid_q <= 1'b0;
         try_cnt      <= '0;
      end else if (accept) begin
         word_idx_q   <= pick_idx;
         letters_q    <= rom_letters;
         word_valid_q <= 1'b1;
         have_last    <= 1'b1;
      end else if (state_q == DRAW) begin
         try_cnt      <= try_cnt + TRY_W'(1);
      end
   end

   assign bus.busy       = (state_q == DRAW);
   assign bus.word_valid = word_valid_q;
   assign bus.word_idx   = word_idx_q;
   assign bus.letters    = letters_q;
   assign dbg_state      = state_q;
   assign dbg_lfsr       = lfsr;

endmodule
